alu_cmd_driver: RTL and testbench
=================================

# alu_cmd_driver

Sequential initiator for the 4-bit combinational ALU. It accepts operation commands over a valid/ready interface and queues them. It drives the ALU's `a`/`b`/`sel` inputs one command per cycle, registers the returned result and flags, and presents them on a valid/ready response port with full backpressure. It sits between a command source (test sequencer, keypad/switch front-end) and the ALU instance.

## Interface
- `W`, 4, operand/result width; must match the ALU.
- `DEPTH`, 2, command queue depth; power of 2, ≥2.

- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous active-low reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  queue can accept
- `cmd_a`, `cmd_b`  in  W  operands
- `cmd_sel`  in  3  opcode, ALU encoding: 000 add, 001 sub, 010 not a, 011 and, 100 or, 101 xor, 110 signed less-than, 111 equal
- `alu_a`, `alu_b`  out  W  to ALU
- `alu_sel`  out  3  to ALU
- `alu_c`  in  W  from ALU
- `alu_cf`, `alu_of`, `alu_out`, `alu_zero`  in  1  from ALU
- `rsp_valid`  out  1  response held
- `rsp_ready`  in  1  consumer accepts
- `rsp_c`  out  W  registered result
- `rsp_flags`  out  4  {cf, of, out, zero}
- `rsp_sel`  out  3  opcode of this response
- `busy`  out  1  queue non-empty or `rsp_valid`
- `err`  out  1  sticky self-check mismatch

## Operation
- **Queue.** The queue is a FIFO of {a, b, sel}.
  - Push when `cmd_valid && cmd_ready`.
  - `cmd_ready = !full`.
  - A push and a pop in the same cycle are both allowed when full; the count is unchanged.
- **ALU drive.** `alu_a`/`alu_b`/`alu_sel` are driven combinationally from the queue head. When the queue is empty they are driven to 0/0/000.
- **FSM**, 3 states:
  - IDLE: queue empty.
  - ISSUE: head valid, and the response register is empty or draining (`!rsp_valid || rsp_ready`).
  - STALL: head valid, `rsp_valid && !rsp_ready`.
  - Transitions are evaluated every cycle from the queue count and the response-register state.
- **ISSUE.** At the clock edge: capture `alu_c`, the four flags and the head `sel` into the response register; set `rsp_valid`; pop the head.
- **STALL.** The head stays on the ALU ports unchanged. There is no capture and no pop.
- **Response drain.** On `rsp_valid && rsp_ready` with no new capture, `rsp_valid` clears. With a simultaneous capture, `rsp_valid` stays 1 and the data is replaced.
- **Ordering.** Responses come out strictly in command order. No command is dropped or duplicated.
- **Capacity.** `DEPTH`+1 commands are outstanding when the response consumer is stalled.
- **Reset.**
  - Output values: all outputs 0, except `cmd_ready`=1; FSM in IDLE; queue pointers 0.
  - Reset mid-operation discards queued commands and any held response.

## Timing
- A command accepted at edge t is issued during cycle t+1. `rsp_valid` rises after edge t+1 if not stalled.
- Issue-to-response latency is 1 cycle.
- Throughput is one command per cycle with `rsp_ready` held high.
- `cmd_ready` depends only on registered count, not on `rsp_ready`.
- The ALU path is treated as single-cycle combinational; no multicycle paths.

## Configuration
- **`ALU_CMD_DRIVER_SELFCHECK_EN` defined.** A golden model computes the expected {c, cf, of, out, zero} from the head. On each capture it is compared with the ALU's returned values.
  - Any mismatch sets `err`. `err` is sticky until `rst_n` is low.
- Golden rules:
  - add: {cf,c}=a+b; of=(a[3]==b[3])&&(c[3]!=a[3]); zero=(c==0).
  - sub: bn=(~b+1) mod 2^W; {k,c}=a+bn; cf=!k; of=(a[3]==bn[3])&&(c[3]!=a[3]); zero=(c==0).
  - Logic ops (010–101): flags all 0, including zero.
  - 110: c=0; out=signed(a)<signed(b).
  - 111: c=0; out=(a==b).
  - Other flags 0.
- **Macro undefined.** There is no model; `err` is tied to 0.

## Structure
- Shared package `alu_pkg` holds:
  - the opcode constants `OP_ADD` … `OP_EQ`;
  - the command struct typedef {a, b, sel};
  - the flag-index constants;
  - the golden-model function `alu_ref`.
- Sub-module `alu_cmd_fifo` is a parameterised synchronous FIFO with async active-low reset, count output and show-ahead head.
- The driver instantiates `alu_cmd_fifo`, the FSM and the response register. The ALU itself is external.

## Test plan
- Add 7+1 → `rsp_c`=8, flags cf=0, of=1, out=0, zero=0, `rsp_valid` two cycles after accept.
- Sub 3−3 → c=0, cf=0, of=0, zero=1. Sub 5−0 → c=5, cf=1.
- Signed compare, a=1000 (−8), b=0001 → c=0, out=1. Equal, a=b=1010 → out=1.
- `rsp_ready` low, push four commands back-to-back (DEPTH=2) → three accepted, `cmd_ready`=0 on the fourth. Raise `rsp_ready` → responses in order, one per cycle; fourth then accepted.
- Assert `rst_n` low mid-stream with a full queue → all outputs reset immediately, `cmd_ready`=1. Later responses contain only post-reset commands.
- With `ALU_CMD_DRIVER_SELFCHECK_EN`, force `alu_c` bit 0 inverted on one add → `err`=1 after that capture, and `err` stays 1 until reset.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the 4-bit ALU command path.
//   - opcode constants OP_ADD .. OP_EQ (ALU sel encoding)
//   - flag bit positions inside the {cf, of, out, zero} vector
//   - alu_cmd_t: one queued command {a, b, sel}
//   - alu_res_t: result {c, flags}
//   - drv_state_t: driver FSM states
//   - alu_ref(): golden model of the external ALU
package alu_pkg;

  localparam int ALU_W = 4;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_NOT = 3'b010;
  localparam logic [2:0] OP_AND = 3'b011;
  localparam logic [2:0] OP_OR  = 3'b100;
  localparam logic [2:0] OP_XOR = 3'b101;
  localparam logic [2:0] OP_LT  = 3'b110;
  localparam logic [2:0] OP_EQ  = 3'b111;

  // Positions within the 4-bit flag vector {cf, of, out, zero}
  localparam int FLAG_CF   = 3;
  localparam int FLAG_OF   = 2;
  localparam int FLAG_OUT  = 1;
  localparam int FLAG_ZERO = 0;

  typedef struct packed {
    logic [ALU_W-1:0] a;
    logic [ALU_W-1:0] b;
    logic [2:0]       sel;
  } alu_cmd_t;

  typedef struct packed {
    logic [ALU_W-1:0] c;
    logic [3:0]       flags;
  } alu_res_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_STALL = 2'd2
  } drv_state_t;

  localparam logic [ALU_W-1:0] ALU_ONE = 1;

  function automatic alu_res_t alu_ref(input alu_cmd_t cmd);
    alu_res_t         res;
    logic [ALU_W:0]   sum;
    logic [ALU_W-1:0] bn;
    res = '0;
    sum = '0;
    bn  = '0;
    case (cmd.sel)
      OP_ADD: begin
        sum                 = {1'b0, cmd.a} + {1'b0, cmd.b};
        res.c               = sum[ALU_W-1:0];
        res.flags[FLAG_CF]  = sum[ALU_W];
        res.flags[FLAG_OF]  = (cmd.a[ALU_W-1] == cmd.b[ALU_W-1]) &&
                              (res.c[ALU_W-1] != cmd.a[ALU_W-1]);
        res.flags[FLAG_ZERO] = (res.c == '0);
      end
      OP_SUB: begin
        // Two's-complement subtract; carry out is inverted to form borrow-style cf
        bn                  = ~cmd.b + ALU_ONE;
        sum                 = {1'b0, cmd.a} + {1'b0, bn};
        res.c               = sum[ALU_W-1:0];
        res.flags[FLAG_CF]  = !sum[ALU_W];
        res.flags[FLAG_OF]  = (cmd.a[ALU_W-1] == bn[ALU_W-1]) &&
                              (res.c[ALU_W-1] != cmd.a[ALU_W-1]);
        res.flags[FLAG_ZERO] = (res.c == '0);
      end
      // Logic ops report no flags at all, not even zero
      OP_NOT: res.c = ~cmd.a;
      OP_AND: res.c = cmd.a & cmd.b;
      OP_OR:  res.c = cmd.a | cmd.b;
      OP_XOR: res.c = cmd.a ^ cmd.b;
      OP_LT:  res.flags[FLAG_OUT] = ($signed(cmd.a) < $signed(cmd.b));
      OP_EQ:  res.flags[FLAG_OUT] = (cmd.a == cmd.b);
      default: res = '0;
    endcase
    return res;
  endfunction

endpackage

// File: rtl/alu_cmd_fifo.sv
// alu_cmd_fifo: synchronous show-ahead FIFO with occupancy count.
//   i_clk, i_rst_n   clock, asynchronous active-low reset (pointers/count)
//   i_push, i_data   write request and data (ignored when full unless popping)
//   i_pop            read request (ignored when empty)
//   o_head           current head entry, valid whenever !o_empty
//   o_count          number of stored entries, 0..DEPTH
//   o_full, o_empty  status derived from the registered count
// DEPTH must be a power of two so the pointers wrap naturally.
module alu_cmd_fifo #(
  parameter int WIDTH = 11,
  parameter int DEPTH = 2
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic [WIDTH-1:0]           o_head,
  output logic [$clog2(DEPTH):0]     o_count,
  output logic                       o_full,
  output logic                       o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0]   CNT_ONE  = 1;
  localparam logic [AW:0]   CNT_FULL = (AW+1)'(DEPTH);
  localparam logic [AW-1:0] PTR_ONE  = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wr_ptr;
  logic [AW-1:0]    r_rd_ptr;
  logic [AW:0]      r_count;
  logic             w_do_push;
  logic             w_do_pop;

  assign o_empty   = (r_count == '0);
  assign o_full    = (r_count == CNT_FULL);
  assign w_do_pop  = i_pop && !o_empty;
  // A full FIFO may still take a write in the same cycle it is popped
  assign w_do_push = i_push && (!o_full || w_do_pop);

  // Storage carries no reset so it maps onto plain RAM/LUT storage
  always_ff @(posedge i_clk) begin
    if (w_do_push) begin
      r_mem[r_wr_ptr] <= i_data;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_do_push) begin
        r_wr_ptr <= r_wr_ptr + PTR_ONE;
      end
      if (w_do_pop) begin
        r_rd_ptr <= r_rd_ptr + PTR_ONE;
      end
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CNT_ONE;
        2'b01:   r_count <= r_count - CNT_ONE;
        default: r_count <= r_count;
      endcase
    end
  end

  assign o_head  = r_mem[r_rd_ptr];
  assign o_count = r_count;

endmodule

// File: rtl/alu_cmd_driver.sv
// alu_cmd_driver: queues ALU commands, drives the external combinational ALU
// from the queue head and registers each result on a valid/ready response port.
//   i_clk, i_rst_n                      clock, asynchronous active-low reset
//   i_cmd_valid/o_cmd_ready             command handshake (ready = queue not full)
//   i_cmd_a, i_cmd_b, i_cmd_sel         command operands and opcode
//   o_alu_a, o_alu_b, o_alu_sel         to ALU, from queue head (0 when empty)
//   i_alu_c, i_alu_cf/of/out/zero       result and flags back from ALU
//   o_rsp_valid/i_rsp_ready             response handshake with full backpressure
//   o_rsp_c, o_rsp_flags, o_rsp_sel     held result, {cf,of,out,zero}, opcode
//   o_busy                              queue non-empty or response held
//   o_err                               sticky golden-model mismatch
// Optional feature macro: ALU_CMD_DRIVER_SELFCHECK_EN enables the golden-model
// comparison on every capture; without it o_err is constant 0.
module alu_cmd_driver
  import alu_pkg::*;
#(
  parameter int W     = 4,
  parameter int DEPTH = 2
) (
  input  logic         i_clk,
  input  logic         i_rst_n,
  input  logic         i_cmd_valid,
  output logic         o_cmd_ready,
  input  logic [W-1:0] i_cmd_a,
  input  logic [W-1:0] i_cmd_b,
  input  logic [2:0]   i_cmd_sel,
  output logic [W-1:0] o_alu_a,
  output logic [W-1:0] o_alu_b,
  output logic [2:0]   o_alu_sel,
  input  logic [W-1:0] i_alu_c,
  input  logic         i_alu_cf,
  input  logic         i_alu_of,
  input  logic         i_alu_out,
  input  logic         i_alu_zero,
  output logic         o_rsp_valid,
  input  logic         i_rsp_ready,
  output logic [W-1:0] o_rsp_c,
  output logic [3:0]   o_rsp_flags,
  output logic [2:0]   o_rsp_sel,
  output logic         o_busy,
  output logic         o_err
);

  alu_cmd_t                  w_push_cmd;
  alu_cmd_t                  w_head;
  logic [$clog2(DEPTH):0]    w_count;
  logic                      w_full;
  logic                      w_empty;
  logic                      w_push;
  logic                      w_issue;
  drv_state_t                w_state;

  logic                      r_rsp_valid;
  logic [W-1:0]              r_rsp_c;
  logic [3:0]                r_rsp_flags;
  logic [2:0]                r_rsp_sel;

  assign w_push_cmd = {i_cmd_a, i_cmd_b, i_cmd_sel};
  assign w_push     = i_cmd_valid && !w_full;

  alu_cmd_fifo #(
    .WIDTH ($bits(alu_cmd_t)),
    .DEPTH (DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_push  (w_push),
    .i_data  (w_push_cmd),
    .i_pop   (w_issue),
    .o_head  (w_head),
    .o_count (w_count),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  // The state is a pure function of queue occupancy and the response
  // register, so it is decoded every cycle rather than stored; this keeps
  // issue on the cycle right after acceptance.
  always_comb begin
    w_state = ST_IDLE;
    if (w_empty) begin
      w_state = ST_IDLE;
    end else if (r_rsp_valid && !i_rsp_ready) begin
      w_state = ST_STALL;
    end else begin
      w_state = ST_ISSUE;
    end
  end

  assign w_issue = (w_state == ST_ISSUE);

  assign o_alu_a   = w_empty ? '0 : w_head.a;
  assign o_alu_b   = w_empty ? '0 : w_head.b;
  assign o_alu_sel = w_empty ? 3'b000 : w_head.sel;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_rsp_valid <= 1'b0;
      r_rsp_c     <= '0;
      r_rsp_flags <= '0;
      r_rsp_sel   <= '0;
    end else begin
      case (w_state)
        ST_ISSUE: begin
          // Capture overwrites any response being drained this same edge
          r_rsp_valid <= 1'b1;
          r_rsp_c     <= i_alu_c;
          r_rsp_flags <= {i_alu_cf, i_alu_of, i_alu_out, i_alu_zero};
          r_rsp_sel   <= w_head.sel;
        end
        ST_STALL: begin
          r_rsp_valid <= r_rsp_valid;
        end
        default: begin
          if (r_rsp_valid && i_rsp_ready) begin
            r_rsp_valid <= 1'b0;
          end
        end
      endcase
    end
  end

  assign o_cmd_ready = !w_full;
  assign o_rsp_valid = r_rsp_valid;
  assign o_rsp_c     = r_rsp_c;
  assign o_rsp_flags = r_rsp_flags;
  assign o_rsp_sel   = r_rsp_sel;
  assign o_busy      = (w_count != '0) || r_rsp_valid;

`ifdef ALU_CMD_DRIVER_SELFCHECK_EN
  alu_res_t w_ref;
  logic     w_mismatch;
  logic     r_err;

  assign w_ref      = alu_ref(w_head);
  assign w_mismatch = ({i_alu_c, i_alu_cf, i_alu_of, i_alu_out, i_alu_zero} != w_ref);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_err <= 1'b0;
    end else if (w_issue && w_mismatch) begin
      r_err <= 1'b1;
    end
  end

  assign o_err = r_err;
`else
  assign o_err = 1'b0;
`endif

endmodule

// File: tb/tb_alu_cmd_driver.sv
// Bench for alu_cmd_driver: behavioural ALU stub, queue-based reference model,
// per-cycle compare on the falling edge, plus literal directed expectations.
module tb_alu_cmd_driver;

  localparam int DEPTH = 2;
`ifdef ALU_CMD_DRIVER_SELFCHECK_EN
  localparam bit SC = 1'b1;
`else
  localparam bit SC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [3:0] cmd_a = '0, cmd_b = '0;
  logic [2:0] cmd_sel = '0;
  logic [3:0] alu_a, alu_b;
  logic [2:0] alu_sel;
  logic [3:0] alu_c;
  logic       alu_cf, alu_of, alu_out, alu_zero;
  logic       rsp_valid;
  logic       rsp_ready = 1'b1;
  logic [3:0] rsp_c;
  logic [3:0] rsp_flags;
  logic [2:0] rsp_sel;
  logic       busy, err;
  logic       inject = 1'b0;

  int n_total = 0;
  int n_pass  = 0;

  alu_cmd_driver #(.W(4), .DEPTH(DEPTH)) dut (
    .i_clk(clk), .i_rst_n(rst_n),
    .i_cmd_valid(cmd_valid), .o_cmd_ready(cmd_ready),
    .i_cmd_a(cmd_a), .i_cmd_b(cmd_b), .i_cmd_sel(cmd_sel),
    .o_alu_a(alu_a), .o_alu_b(alu_b), .o_alu_sel(alu_sel),
    .i_alu_c(alu_c), .i_alu_cf(alu_cf), .i_alu_of(alu_of),
    .i_alu_out(alu_out), .i_alu_zero(alu_zero),
    .o_rsp_valid(rsp_valid), .i_rsp_ready(rsp_ready),
    .o_rsp_c(rsp_c), .o_rsp_flags(rsp_flags), .o_rsp_sel(rsp_sel),
    .o_busy(busy), .o_err(err)
  );

  always #5 clk = ~clk;

  // Integer-arithmetic ALU: returns {c, cf, of, out, zero}
  function automatic logic [7:0] ref_alu(input logic [3:0] a, input logic [3:0] b,
                                         input logic [2:0] sel);
    int ia, ib, sa, sb, r, bn, sbn;
    logic [3:0] c;
    logic cf, of, o, z;
    ia = int'(a); ib = int'(b);
    sa = (ia >= 8) ? ia - 16 : ia;
    sb = (ib >= 8) ? ib - 16 : ib;
    c = 4'd0; cf = 1'b0; of = 1'b0; o = 1'b0; z = 1'b0;
    case (sel)
      3'd0: begin
        r = ia + ib; c = 4'(r % 16); cf = (r > 15);
        of = (sa + sb > 7) || (sa + sb < -8); z = (c == 4'd0);
      end
      3'd1: begin
        bn = (16 - ib) % 16; r = ia + bn; c = 4'(r % 16); cf = (r < 16);
        sbn = (bn >= 8) ? bn - 16 : bn;
        of = (sa + sbn > 7) || (sa + sbn < -8); z = (c == 4'd0);
      end
      3'd2: c = 4'(15 - ia);
      3'd3: c = a & b;
      3'd4: c = a | b;
      3'd5: c = a ^ b;
      3'd6: o = (sa < sb);
      default: o = (ia == ib);
    endcase
    return {c, cf, of, o, z};
  endfunction

  // External ALU stub, with optional bit-0 corruption on adds
  always_comb begin
    logic [7:0] r;
    r = ref_alu(alu_a, alu_b, alu_sel);
    if (SC && inject && alu_sel == 3'd0) r[4] = ~r[4];
    {alu_c, alu_cf, alu_of, alu_out, alu_zero} = r;
  end

  task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h at %0t", nm, act, exp, $time);
  endtask

  // ---------------- reference model ----------------
  typedef struct { logic [3:0] a; logic [3:0] b; logic [2:0] sel; } tcmd_t;
  tcmd_t      mq[$];
  bit         m_rv = 1'b0;
  logic [3:0] m_c = '0;
  logic [3:0] m_f = '0;
  logic [2:0] m_sel = '0;
  bit         m_err = 1'b0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete(); m_rv = 1'b0; m_err = 1'b0;
    end else begin
      bit acc, iss;
      tcmd_t h, n;
      logic [7:0] r;
      acc = cmd_valid && (mq.size() < DEPTH);
      iss = (mq.size() > 0) && (!m_rv || rsp_ready);
      n.a = cmd_a; n.b = cmd_b; n.sel = cmd_sel;
      if (iss) begin
        h = mq.pop_front();
        r = ref_alu(h.a, h.b, h.sel);
        if (SC && inject && h.sel == 3'd0) begin
          r[4] = ~r[4];
          m_err = 1'b1;
        end
        m_c = r[7:4]; m_f = r[3:0]; m_sel = h.sel; m_rv = 1'b1;
      end else if (m_rv && rsp_ready) begin
        m_rv = 1'b0;
      end
      if (acc) mq.push_back(n);
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    logic [3:0] ea, eb;
    logic [2:0] es;
    ea = 4'd0; eb = 4'd0; es = 3'd0;
    if (mq.size() > 0) begin ea = mq[0].a; eb = mq[0].b; es = mq[0].sel; end
    chk("cmd_ready", {7'd0, cmd_ready}, {7'd0, mq.size() < DEPTH});
    chk("rsp_valid", {7'd0, rsp_valid}, {7'd0, m_rv});
    chk("busy", {7'd0, busy}, {7'd0, (mq.size() > 0) || m_rv});
    chk("alu_drive", {1'b0, alu_a, alu_sel}, {1'b0, ea, es});
    chk("alu_b", {4'd0, alu_b}, {4'd0, eb});
    chk("err", {7'd0, err}, {7'd0, m_err});
    if (m_rv) begin
      chk("rsp_c_flags", {rsp_c, rsp_flags}, {m_c, m_f});
      chk("rsp_sel", {5'd0, rsp_sel}, {5'd0, m_sel});
    end
    if (rst_n && rsp_valid && rsp_ready)
      $display("rsp sel=%0d c=%h flags=%b", rsp_sel, rsp_c, rsp_flags);
  end

  // ---------------- directed helpers ----------------
  task automatic directed(input string nm, input logic [3:0] a, input logic [3:0] b,
                          input logic [2:0] sel, input logic [3:0] ec, input logic [3:0] ef);
    @(posedge clk); #1;
    cmd_valid = 1'b1; cmd_a = a; cmd_b = b; cmd_sel = sel;
    @(negedge clk);
    chk({nm, "_ready"}, {7'd0, cmd_ready}, 8'd1);
    @(posedge clk); #1;              // accept edge t
    cmd_valid = 1'b0;
    @(negedge clk);
    chk({nm, "_early"}, {7'd0, rsp_valid}, 8'd0);
    @(negedge clk);                  // after edge t+1
    chk({nm, "_valid"}, {7'd0, rsp_valid}, 8'd1);
    chk({nm, "_c"}, {4'd0, rsp_c}, {4'd0, ec});
    chk({nm, "_flags"}, {4'd0, rsp_flags}, {4'd0, ef});
    chk({nm, "_sel"}, {5'd0, rsp_sel}, {5'd0, sel});
  endtask

  task automatic check_reset_outputs(input string nm);
    chk({nm, "_ready"}, {7'd0, cmd_ready}, 8'd1);
    chk({nm, "_rsp"}, {rsp_valid, busy, err, rsp_sel, 2'd0}, 8'd0);
    chk({nm, "_data"}, {rsp_c, rsp_flags}, 8'd0);
    chk({nm, "_alu"}, {1'b0, alu_a, alu_sel}, 8'd0);
    chk({nm, "_alub"}, {4'd0, alu_b}, 8'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen[4];
    int accepted;
    bit got;

    #12;
    check_reset_outputs("reset");
    #11 rst_n = 1'b1;

    // Literal ALU results
    directed("add7p1", 4'd7, 4'd1, 3'd0, 4'd8, 4'b0100);
    directed("sub3m3", 4'd3, 4'd3, 3'd1, 4'd0, 4'b0001);
    directed("sub5m0", 4'd5, 4'd0, 3'd1, 4'd5, 4'b1000);
    directed("slt",    4'b1000, 4'b0001, 3'd6, 4'd0, 4'b0010);
    directed("eq",     4'b1010, 4'b1010, 3'd7, 4'd0, 4'b0010);
    directed("xor0",   4'd5, 4'd5, 3'd5, 4'd0, 4'b0000);
    directed("not",    4'b0011, 4'd0, 3'd2, 4'b1100, 4'b0000);

    // Backpressure: four back-to-back pushes with the consumer stalled
    repeat (2) @(posedge clk);
    #1 rsp_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      cmd_valid = 1'b1; cmd_a = 4'(i + 1); cmd_b = 4'(2 * i); cmd_sel = 3'(i);
      @(negedge clk); seen[i] = cmd_ready;
      @(posedge clk); #1;
    end
    accepted = 0;
    for (int i = 0; i < 4; i++) accepted += int'(seen[i]);
    chk("bp_accepted", 8'(accepted), 8'd3);
    chk("bp_fourth_ready", {7'd0, seen[3]}, 8'd0);
    repeat (2) @(posedge clk);
    #1 rsp_ready = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      @(negedge clk); got = cmd_ready;
      @(posedge clk); #1;
    end
    chk("bp_fourth_accepted", {7'd0, got}, 8'd1);
    cmd_valid = 1'b0;
    repeat (4) @(posedge clk);

    // Reset mid-stream with a full queue and a held response
    #1 rsp_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      cmd_valid = 1'b1; cmd_a = 4'(9 + i); cmd_b = 4'd3; cmd_sel = 3'd0;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    @(negedge clk);
    chk("pre_reset_full", {6'd0, cmd_ready, rsp_valid}, 8'd1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 check_reset_outputs("midreset");
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    rsp_ready = 1'b1;
    directed("postreset", 4'd2, 4'd3, 3'd0, 4'd5, 4'b0000);
    repeat (2) @(posedge clk);

    // Randomised traffic against the model
    for (int i = 0; i < 600; i++) begin
      @(posedge clk); #1;
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a = 4'($urandom); cmd_b = 4'($urandom); cmd_sel = 3'($urandom);
      rsp_ready = ($urandom_range(0, 3) != 0);
    end
    @(posedge clk); #1;
    cmd_valid = 1'b0; rsp_ready = 1'b1;
    repeat (6) @(posedge clk);

`ifdef ALU_CMD_DRIVER_SELFCHECK_EN
    inject = 1'b1;
    directed("inject_add", 4'd2, 4'd2, 3'd0, 4'd5, 4'b0000);
    inject = 1'b0;
    chk("err_set", {7'd0, err}, 8'd1);
    directed("after_inject", 4'd1, 4'd1, 3'd0, 4'd2, 4'b0000);
    chk("err_sticky", {7'd0, err}, 8'd1);
    @(posedge clk); #3 rst_n = 1'b0;
    #1 chk("err_cleared", {7'd0, err}, 8'd0);
    @(posedge clk); #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);
`endif

    @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
